// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer for the 6502 core: arbitrates reset/NMI/BRK/IRQ and
// steps the shared datapath through three stack pushes and a two-byte vector fetch.
module interrupt_sequencer (
  input  logic        ph1,
  input  logic        reset,
  input  logic        nmib,
  input  logic        irqb,
  input  logic        iflag,
  input  logic        brk_req,
  input  logic        instr_boundary,
  output logic        seq_busy,
  output logic [1:0]  addr_sel,
  output logic [15:0] vector_addr,
  output logic [1:0]  push_sel,
  output logic        b_flag,
  output logic        mem_we,
  output logic        sp_dec,
  output logic        pcl_load,
  output logic        pch_load,
  output logic        set_iflag,
  output logic [1:0]  svc_kind
);

  typedef enum logic [2:0] {RSTW, IDLE, PCH, PCL, PSR, VLO, VHI} state_t;

  localparam logic [1:0] KIND_RESET = 2'b01;
  localparam logic [1:0] KIND_NMI   = 2'b10;
  localparam logic [1:0] KIND_IRQ   = 2'b11;

  state_t     state;
  logic [1:0] kind;
  logic       brk_captured;
  logic       nmi_prev;
  logic       nmi_pend;
  logic       pend_clear;
  logic [15:0] base;

  // The pending NMI is consumed as the sequence enters VLO on the NMI vector,
  // including an IRQ/BRK sequence that gets hijacked on the way.
  assign pend_clear = (state == PSR) &&
                      ((kind == KIND_NMI) || ((kind == KIND_IRQ) && nmi_pend));

  always_ff @(posedge ph1) begin
    if (reset) begin
      state        <= RSTW;
      kind         <= KIND_RESET;
      brk_captured <= 1'b0;
      nmi_prev     <= 1'b1;
      nmi_pend     <= 1'b0;
    end else begin
      nmi_prev <= nmib;
      case (state)
        RSTW: state <= PCH;
        IDLE: begin
          if (nmi_pend && instr_boundary) begin
            kind         <= KIND_NMI;
            brk_captured <= 1'b0;
            state        <= PCH;
          end else if (brk_req) begin
            kind         <= KIND_IRQ;
            brk_captured <= 1'b1;
            state        <= PCH;
          end else if (!irqb && !iflag && instr_boundary) begin
            kind         <= KIND_IRQ;
            brk_captured <= 1'b0;
            state        <= PCH;
          end
        end
        PCH: state <= PCL;
        PCL: state <= PSR;
        PSR: begin
          if ((kind == KIND_IRQ) && nmi_pend) kind <= KIND_NMI;
          state <= VLO;
        end
        VLO: state <= VHI;
        VHI: state <= IDLE;
        default: state <= RSTW;
      endcase
      // A fresh falling edge wins over a same-cycle clear so it is never lost.
      if (nmi_prev && !nmib) nmi_pend <= 1'b1;
      else if (pend_clear)   nmi_pend <= 1'b0;
    end
  end

  always_comb begin
    case (kind)
      KIND_NMI:   base = 16'hFFFA;
      KIND_RESET: base = 16'hFFFC;
      default:    base = 16'hFFFE;
    endcase
  end

  always_comb begin
    seq_busy    = (state != IDLE);
    addr_sel    = 2'b00;
    push_sel    = 2'b00;
    mem_we      = 1'b0;
    sp_dec      = 1'b0;
    pcl_load    = 1'b0;
    pch_load    = 1'b0;
    set_iflag   = 1'b0;
    b_flag      = brk_captured;
    vector_addr = base;
    svc_kind    = kind;
    case (state)
      RSTW: svc_kind = KIND_RESET;
      IDLE: svc_kind = 2'b00;
      PCH, PCL, PSR: begin
        addr_sel = 2'b01;
        sp_dec   = 1'b1;
        mem_we   = (kind != KIND_RESET);
        if (state == PCL)      push_sel = 2'b01;
        else if (state == PSR) push_sel = 2'b10;
      end
      VLO: begin
        addr_sel = 2'b10;
        pcl_load = 1'b1;
      end
      VHI: begin
        addr_sel    = 2'b10;
        vector_addr = base | 16'h0001;
        pch_load    = 1'b1;
        set_iflag   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios plus random
// traffic compared each cycle against a step-counting reference model.
module tb_interrupt_sequencer;

  logic        ph1 = 1'b0;
  logic        reset, nmib, irqb, iflag, brk_req, instr_boundary;
  logic        seq_busy, b_flag, mem_we, sp_dec, pcl_load, pch_load, set_iflag;
  logic [1:0]  addr_sel, push_sel, svc_kind;
  logic [15:0] vector_addr;

  always #5 ph1 = ~ph1;

  interrupt_sequencer dut (
    .ph1(ph1), .reset(reset), .nmib(nmib), .irqb(irqb), .iflag(iflag),
    .brk_req(brk_req), .instr_boundary(instr_boundary),
    .seq_busy(seq_busy), .addr_sel(addr_sel), .vector_addr(vector_addr),
    .push_sel(push_sel), .b_flag(b_flag), .mem_we(mem_we), .sp_dec(sp_dec),
    .pcl_load(pcl_load), .pch_load(pch_load), .set_iflag(set_iflag),
    .svc_kind(svc_kind)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: mStep -1 = waiting out reset, 0 = idle, 1..5 = cycles into entry.
  int         mStep = -1;
  logic [1:0] mKind = 2'b01;
  logic       mB = 1'b0, mPend = 1'b0, mPrev = 1'b1;

  int          spCount, weCount, setCount;
  logic        pushedB;
  logic [15:0] pc, lastVec;
  logic [1:0]  kindAtVlo;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [7:0] vecByte(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h00;
      16'hFFFB: return 8'hE0;
      16'hFFFC: return 8'h00;
      16'hFFFD: return 8'hF0;
      16'hFFFE: return 8'h05;
      16'hFFFF: return 8'hF0;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic void modelAdvance();
    logic fell, clear;
    if (reset) begin
      mStep = -1; mKind = 2'b01; mB = 1'b0; mPend = 1'b0; mPrev = 1'b1;
      return;
    end
    fell  = mPrev && !nmib;
    mPrev = nmib;
    clear = 1'b0;
    case (mStep)
      -1: mStep = 1;
      0: begin
        if (mPend && instr_boundary) begin mKind = 2'b10; mB = 1'b0; mStep = 1; end
        else if (brk_req) begin mKind = 2'b11; mB = 1'b1; mStep = 1; end
        else if (!irqb && !iflag && instr_boundary) begin mKind = 2'b11; mB = 1'b0; mStep = 1; end
      end
      1, 2: mStep = mStep + 1;
      3: begin
        if (mKind == 2'b11 && mPend) mKind = 2'b10;
        if (mKind == 2'b10) clear = 1'b1;
        mStep = 4;
      end
      4: mStep = 5;
      default: mStep = 0;
    endcase
    if (fell) mPend = 1'b1;
    else if (clear) mPend = 1'b0;
  endfunction

  function automatic logic [12:0] expectedCtl();
    logic       push, busy;
    logic [1:0] a, p, k;
    busy = (mStep != 0);
    push = (mStep >= 1 && mStep <= 3);
    a = push ? 2'b01 : (mStep >= 4 ? 2'b10 : 2'b00);
    p = (mStep == 2) ? 2'b01 : ((mStep == 3) ? 2'b10 : 2'b00);
    k = (mStep == -1) ? 2'b01 : ((mStep == 0) ? 2'b00 : mKind);
    return {busy, a, p, push && (mKind != 2'b01), push, mStep == 4, mStep == 5,
            mStep == 5, k, mB};
  endfunction

  function automatic logic [15:0] expectedVector();
    logic [15:0] b;
    b = (mKind == 2'b10) ? 16'hFFFA : ((mKind == 2'b01) ? 16'hFFFC : 16'hFFFE);
    return (mStep == 5) ? (b + 16'd1) : b;
  endfunction

  task automatic applyStimulus();
    modelAdvance();
    @(posedge ph1);
    #1;
    checkOutput("ctl", {3'b000, seq_busy, addr_sel, push_sel, mem_we, sp_dec, pcl_load,
                        pch_load, set_iflag, svc_kind, b_flag},
                {3'b000, expectedCtl()});
    if (mStep == -1 || mStep >= 4) checkOutput("vector", vector_addr, expectedVector());
    if (sp_dec) spCount++;
    if (mem_we) weCount++;
    if (set_iflag) setCount++;
    if (mem_we && push_sel == 2'b10) pushedB = b_flag;
    if (pcl_load) begin pc[7:0] = vecByte(vector_addr); lastVec = vector_addr; kindAtVlo = svc_kind; end
    if (pch_load) pc[15:8] = vecByte(vector_addr);
  endtask

  task automatic clearCounters();
    spCount = 0; weCount = 0; setCount = 0; pushedB = 1'bx; pc = 16'h0000;
    lastVec = 16'h0000; kindAtVlo = 2'b00;
  endtask

  initial begin
    reset = 1'b1; nmib = 1'b1; irqb = 1'b1; iflag = 1'b1; brk_req = 1'b0;
    instr_boundary = 1'b0;
    clearCounters();

    // Reset release: dummy pushes, then the FFFC vector.
    repeat (3) applyStimulus();
    checkOutput("rst_busy", {15'd0, seq_busy}, 16'd1);
    checkOutput("rst_vec", vector_addr, 16'hFFFC);
    reset = 1'b0;
    clearCounters();
    repeat (6) applyStimulus();
    checkOutput("rst_spdec", 16'(spCount), 16'd3);
    checkOutput("rst_we", 16'(weCount), 16'd0);
    checkOutput("rst_pc", pc, 16'hF000);
    checkOutput("rst_idle", {15'd0, seq_busy}, 16'd0);

    // BRK ignores the I flag and the boundary.
    clearCounters();
    brk_req = 1'b1;
    applyStimulus();
    brk_req = 1'b0;
    repeat (5) applyStimulus();
    checkOutput("brk_spdec", 16'(spCount), 16'd3);
    checkOutput("brk_we", 16'(weCount), 16'd3);
    checkOutput("brk_bflag", {15'd0, pushedB}, 16'd1);
    checkOutput("brk_seti", 16'(setCount), 16'd1);
    checkOutput("brk_pc", pc, 16'hF005);

    // Masked IRQ, then unmasked at a boundary.
    irqb = 1'b0; instr_boundary = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("irq_masked", {15'd0, seq_busy}, 16'd0);
    clearCounters();
    iflag = 1'b0;
    applyStimulus();
    iflag = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("irq_bflag", {15'd0, pushedB}, 16'd0);
    checkOutput("irq_vec", lastVec, 16'hFFFE);
    checkOutput("irq_pc", pc, 16'hF005);
    irqb = 1'b1;

    // NMI, BRK and IRQ all requested together: NMI wins.
    clearCounters();
    nmib = 1'b0; instr_boundary = 1'b0;
    applyStimulus();
    irqb = 1'b0; brk_req = 1'b1; instr_boundary = 1'b1; iflag = 1'b0;
    applyStimulus();
    brk_req = 1'b0; iflag = 1'b1; nmib = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("nmi_vec", lastVec, 16'hFFFA);
    checkOutput("nmi_pc", pc, 16'hE000);
    repeat (3) applyStimulus();
    checkOutput("nmi_after_idle", {15'd0, seq_busy}, 16'd0);
    irqb = 1'b1;

    // NMI edge during PCL of a BRK hijacks the vector but keeps B=1.
    clearCounters();
    brk_req = 1'b1; instr_boundary = 1'b0;
    applyStimulus();
    brk_req = 1'b0;
    applyStimulus();
    nmib = 1'b0;
    applyStimulus();
    nmib = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("hij_vec", lastVec, 16'hFFFA);
    checkOutput("hij_kind", {14'd0, kindAtVlo}, 16'd2);
    checkOutput("hij_bflag", {15'd0, pushedB}, 16'd1);
    checkOutput("hij_pc", pc, 16'hE000);

    // Reset during PSR of an IRQ, with an NMI pending that must be discarded.
    iflag = 1'b0; irqb = 1'b0; instr_boundary = 1'b1;
    applyStimulus();
    iflag = 1'b1; irqb = 1'b1; nmib = 1'b0;
    applyStimulus();
    applyStimulus();
    clearCounters();
    reset = 1'b1; nmib = 1'b1;
    applyStimulus();
    checkOutput("abort_busy", {15'd0, seq_busy}, 16'd1);
    checkOutput("abort_kind", {14'd0, svc_kind}, 16'd1);
    reset = 1'b0;
    repeat (6) applyStimulus();
    checkOutput("abort_we", 16'(weCount), 16'd0);
    checkOutput("abort_spdec", 16'(spCount), 16'd3);
    checkOutput("abort_pc", pc, 16'hF000);
    repeat (3) applyStimulus();
    checkOutput("abort_pend_gone", {15'd0, seq_busy}, 16'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 59) == 0);
      brk_req        = (mStep == 0) && ($urandom_range(0, 9) == 0);
      irqb           = ($urandom_range(0, 3) != 0);
      iflag          = 1'($urandom_range(0, 1));
      instr_boundary = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) nmib = ~nmib;
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Controller that arbitrates the 6502 core's interrupt sources (reset, NMI, BRK, IRQ) and sequences the shared address/data datapath through the interrupt entry: it pushes PCH, PCL and P to the stack page, then fetches the vector. It sits between the instruction decoder and the bus/register-file muxes in `top`. It only emits select and strobe controls; the existing PC, SP and memory datapath performs the data movement.

## Interface
- No parameters.
- `ph1` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `nmib` in 1: NMI, active-low, falling-edge triggered.
- `irqb` in 1: IRQ, active-low, level-sensitive.
- `iflag` in 1: CPU P.I flag; masks IRQ only.
- `brk_req` in 1: one-cycle pulse from the decoder when a BRK opcode is decoded.
- `instr_boundary` in 1: the CPU is at an opcode-fetch boundary. NMI and IRQ are accepted only here.
- `seq_busy` out 1: a sequence is in progress; the decoder stalls.
- `addr_sel` out 2: 00 PC, 01 stack {8'h01,SP}, 10 vector.
- `vector_addr` out 16: FFFA NMI, FFFC reset, FFFE IRQ/BRK.
- `push_sel` out 2: 00 PCH, 01 PCL, 10 P.
- `b_flag` out 1: value driven into bit 4 of the pushed P.
- `mem_we` out 1: write strobe for stack pushes.
- `sp_dec` out 1: decrement SP this cycle.
- `pcl_load` / `pch_load` out 1: load PC byte from the data bus.
- `set_iflag` out 1: one-cycle pulse that sets P.I.
- `svc_kind` out 2: 00 none, 01 reset, 10 NMI, 11 IRQ/BRK.

## Operation
- States: RSTW, IDLE, PCH, PCL, PSR, VLO, VHI.
- While `reset`=1, the state is forced to RSTW. The kind register is set to reset, the NMI-pending latch is cleared, and the NMI edge register is loaded with 1.
- Reset values of outputs (RSTW):
  - `seq_busy`=1, `svc_kind`=01.
  - All other outputs are 0; `vector_addr`=FFFC.
- RSTW → PCH on the first cycle with `reset`=0.
- NMI edge detect:
  - `nmi_prev` is registered every cycle.
  - `nmib`=0 with `nmi_prev`=1 sets `nmi_pend`.
  - `nmi_pend` is cleared on entry to VLO when the vector is FFFA.
- Acceptance happens in IDLE only. Priority is NMI > BRK > IRQ:
  - NMI is taken if `nmi_pend` & `instr_boundary`.
  - BRK is taken if `brk_req`, regardless of `iflag` or `instr_boundary`.
  - IRQ is taken if `irqb`=0 & `iflag`=0 & `instr_boundary`. It is not latched; a deasserted line is simply not taken.
- On acceptance, the block captures `kind` and `b_flag` (1 for BRK, 0 otherwise), then goes IDLE → PCH.
- Per-state outputs (all states except IDLE assert `seq_busy`):
  - PCH: `addr_sel`=01, `push_sel`=00, `mem_we`, `sp_dec`.
  - PCL: `addr_sel`=01, `push_sel`=01, `mem_we`, `sp_dec`.
  - PSR: `addr_sel`=01, `push_sel`=10, `mem_we`, `sp_dec`.
  - VLO: `addr_sel`=10, `vector_addr`=base, `pcl_load`.
  - VHI: `addr_sel`=10, `vector_addr`=base+1, `pch_load`, `set_iflag`.
  - VHI → IDLE.
- Reset kind: `mem_we` is held 0 in PCH/PCL/PSR (dummy pushes), but `sp_dec` still pulses three times.
- NMI hijack:
  - If `nmi_pend` is set while in PCH, PCL or PSR of an IRQ/BRK sequence, the base switches to FFFA at VLO and `svc_kind` becomes 10.
  - `b_flag` keeps its captured value, so a hijacked BRK still pushes B=1.
  - Hijack never applies to a reset sequence.
- `brk_req` arriving while `seq_busy`=1 is ignored. The decoder must not issue one.
- `reset` asserted mid-sequence aborts immediately: next state is RSTW, with no further `mem_we` or load strobes.

## Timing
- Acceptance in cycle N gives PCH at N+1, PCL at N+2, PSR at N+3, VLO at N+4, VHI at N+5, IDLE at N+6.
- `seq_busy` falls at N+6. A new request can be accepted at N+6.
- An NMI edge at cycle E is eligible for acceptance from E+1.
- `set_iflag` pulses in VHI only. The CPU presents `iflag`=1 from the next cycle, so IRQ cannot re-enter immediately.
- `svc_kind` is valid from PCH through VHI. It reads 00 in IDLE and 01 in RSTW.
- The outputs are a combinational decode of registered state, so there are no input-to-output combinational paths except that hijack uses registered `nmi_pend`.

## Test plan
- Reset release with vector bytes FFFC/FFFD = 00/F0 → exactly 3 `sp_dec` and 0 `mem_we`; `pcl_load` at N+4 on address FFFC; `pch_load` at N+5 on FFFD; PC=F000 and IDLE at N+6.
- `brk_req` with `iflag`=1 and BRK vector FFFE/FFFF = 05/F0 → 3 pushes with `b_flag`=1; `set_iflag` at N+5; PC=F005. A handler storing 8'h42 to RAM[96] leaves 42 at 0x0060.
- `irqb`=0 with `iflag`=1 → no acceptance. Clear `iflag` at a boundary → sequence starts, `b_flag`=0, vector FFFE.
- Simultaneous `nmi_pend`, `irqb`=0 and `brk_req` in IDLE at a boundary → NMI is taken first with vector FFFA and `nmi_pend` cleared at VLO. The IRQ is masked afterwards.
- NMI falling edge during PCL of a BRK sequence → VLO address FFFA, `svc_kind`=10, pushed P has B=1.
- `reset` asserted in PSR of an IRQ sequence → next cycle is RSTW with `mem_we`=0, `nmi_pend` cleared, outputs at reset values. Release → full reset sequence.
